m_lsexc_bridge: RTL
===================

Name: m_lsexc_bridge

Overview:
- Sequential successor to the M-stage load/store exception check, combined with the data-side bus bridge.
- Accepts one load/store request at a time and checks it against N_DEV parametrised address windows, producing AdEL/AdES with the faulting address.
- For legal accesses it runs a valid/ack handshake with the selected device, with a timeout. Drives the pipeline stall until the response cycle.

Parameters:
- N_DEV, 3: number of address windows (device 0 = DM, 1 = Timer0, 2 = Timer1).
- DEV_BASE, {32'h7F10,32'h7F00,32'h0000}: packed 32*N_DEV window base addresses, index 0 in LSBs.
- DEV_LIMIT, {32'h7F1B,32'h7F0B,32'h2FFF}: packed inclusive window limits.
- DEV_WORD_ONLY, 3'b110: bit i set means device i accepts word accesses only.
- DEV_RO_OFS, {32'd8,32'd8,32'h3000}: per-window byte offset at or above which stores are illegal (read-only region).
- TIMEOUT, 15: maximum WAIT cycles without ack; must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_addr  in  32  byte address.
- req_ovf  in  1  address adder overflowed.
- req_ready  out  1  high in IDLE only.
- flush  in  1  kill the in-flight request.
- dev_valid  out  1  device request strobe.
- dev_sel  out  N_DEV  one-hot device select.
- dev_ack  in  N_DEV  per-device acknowledge.
- rsp_valid  out  1  one-cycle response.
- rsp_adel  out  1  load address exception.
- rsp_ades  out  1  store address exception.
- rsp_berr  out  1  response caused by timeout.
- rsp_badvaddr  out  32  faulting address; meaningful only when adel or ades is set.
- stall  out  1  pipeline hold.
- stat_adel  out  16  AdEL count (optional feature).
- stat_ades  out  16  AdES count (optional feature).

Behaviour:
- Reset: state IDLE; all outputs, the latched request and the counters are 0.
- States: IDLE, CHECK, WAIT, RESP.
- IDLE:
  - Accepts when req_valid & (req_load | req_store).
  - Latches addr/size/type/ovf and goes to CHECK.
  - If both load and store are set, the request is treated as a store.
  - req_valid with neither load nor store is ignored.
- CHECK (one cycle): hit window = lowest index i with DEV_BASE[i] <= addr <= DEV_LIMIT[i]. An access is illegal if any of:
  - misaligned: word with addr[1:0] != 0, or half with addr[0] = 1;
  - req_size = 3;
  - no window hit;
  - DEV_WORD_ONLY[hit] set and size is not word;
  - store with addr - DEV_BASE[hit] >= DEV_RO_OFS[hit];
  - ovf set.
- CHECK result:
  - Illegal: go to RESP with adel (load) or ades (store) and badvaddr = addr; no device access.
  - Legal: go to WAIT.
- WAIT:
  - dev_valid = 1 and dev_sel = onehot(hit), held stable.
  - dev_ack[hit] sampled high goes to RESP, no error.
  - Acks from other devices are ignored.
  - The cycle counter starts at 0 on entry. If it reaches TIMEOUT without ack, go to RESP with rsp_berr = 1, adel/ades set per type and badvaddr = addr.
- RESP: rsp_* valid for exactly one cycle, then IDLE. Back-to-back requests are accepted from the following IDLE cycle.
- Response flags: rsp_adel, rsp_ades, rsp_berr and rsp_badvaddr are 0 whenever rsp_valid = 0. They are mutually exclusive by type (adel vs ades).
- stall = state in {CHECK, WAIT}, plus IDLE while accepting a request.
- Latency:
  - Exception: rsp_valid 2 cycles after the accept edge.
  - Ack seen on the first WAIT cycle: rsp_valid 3 cycles after the accept edge.
- flush:
  - In any non-IDLE state, the next state is IDLE.
  - No rsp_valid is produced; dev_valid drops the next cycle; counters are unchanged.
  - flush in IDLE blocks acceptance that cycle.
- Address compare: unsigned 32-bit; window limits are inclusive.
- Mid-operation reset: immediately IDLE with all outputs 0.

Optional Feature:
- Macro: LSEXC_STAT_EN.
- Defined: stat_adel and stat_ades are 16-bit saturating counters (stick at 16'hFFFF).
  - Each increments in the RESP cycle where the corresponding flag is set.
  - Timeouts count as well.
  - Cleared by reset.
- Not defined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- lw 0x0000_1004, dev_ack[0] high on the first WAIT cycle -> dev_sel = 001; rsp_valid 3 cycles after accept; adel = ades = 0.
- lh 0x0000_0003 -> no dev_valid; rsp_valid 2 cycles after accept; rsp_adel = 1; rsp_badvaddr = 0x0000_0003.
- Stores to Timer0:
  - sw 0x7F08 -> ades (read-only count register).
  - sb 0x7F04 -> ades (word-only device).
  - sw 0x7F04 with ack -> legal.
- lw 0x0000_3000 (gap between windows) -> adel. lw 0x7F10 with req_ovf = 1 -> adel.
- sw 0x7F14 with no ack -> WAIT for 15 cycles, then rsp_valid with ades = 1, berr = 1; stall high throughout.
- flush during WAIT -> IDLE next cycle; no rsp_valid; req_ready = 1. With LSEXC_STAT_EN, stat_ades unchanged.

Source files
------------

// File: rtl/m_lsexc_bridge.sv
// m_lsexc_bridge
//
// M-stage load/store exception check combined with the data-side bus bridge.
// One request at a time is latched, checked against N_DEV address windows and
// either answered immediately with AdEL/AdES or forwarded to the selected
// device with a valid/ack handshake bounded by TIMEOUT cycles.
//
// State table
//   state   | meaning
//   IDLE    | ready for a request; req_ready_o high once settled after reset
//   CHECK   | latched request is checked against the windows (one cycle)
//   WAIT    | dev_valid_o/dev_sel_o held, waiting for dev_ack_i[hit]
//   RESP    | one-cycle response on rsp_*_o
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/load/store/size/addr/ovf   request from the pipeline
//   req_ready_o                   high in IDLE only
//   flush_i                       kill the in-flight request, no response
//   dev_valid_o, dev_sel_o        device strobe and one-hot select
//   dev_ack_i                     per-device acknowledge
//   rsp_valid_o, rsp_adel_o, rsp_ades_o, rsp_berr_o, rsp_badvaddr_o   response
//   stall_o                       pipeline hold
//   stat_adel_o, stat_ades_o      saturating exception counters
//
// Optional feature: define LSEXC_STAT_EN to build the exception counters;
// otherwise both stat outputs are tied to zero.

module m_lsexc_bridge #(
    parameter int                 N_DEV         = 3,
    parameter logic [32*N_DEV-1:0] DEV_BASE     = {32'h7F10, 32'h7F00, 32'h0000},
    parameter logic [32*N_DEV-1:0] DEV_LIMIT    = {32'h7F1B, 32'h7F0B, 32'h2FFF},
    parameter logic [N_DEV-1:0]   DEV_WORD_ONLY = 3'b110,
    parameter logic [32*N_DEV-1:0] DEV_RO_OFS   = {32'd8, 32'd8, 32'h3000},
    parameter int                 TIMEOUT       = 15
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    input  logic               req_load_i,
    input  logic               req_store_i,
    input  logic [1:0]         req_size_i,
    input  logic [31:0]        req_addr_i,
    input  logic               req_ovf_i,
    output logic               req_ready_o,
    input  logic               flush_i,
    output logic               dev_valid_o,
    output logic [N_DEV-1:0]   dev_sel_o,
    input  logic [N_DEV-1:0]   dev_ack_i,
    output logic               rsp_valid_o,
    output logic               rsp_adel_o,
    output logic               rsp_ades_o,
    output logic               rsp_berr_o,
    output logic [31:0]        rsp_badvaddr_o,
    output logic               stall_o,
    output logic [15:0]        stat_adel_o,
    output logic [15:0]        stat_ades_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q;
    logic [31:0]        addr_q;
    logic [1:0]         size_q;
    logic               store_q;
    logic               ovf_q;
    logic [CW-1:0]      cnt_q;
    logic               ready_q;
    logic               stall_q;
    logic               dev_valid_q;
    logic [N_DEV-1:0]   dev_sel_q;
    logic               rsp_valid_q;
    logic               rsp_adel_q;
    logic               rsp_ades_q;
    logic               rsp_berr_q;
    logic [31:0]        rsp_badvaddr_q;

    logic               accept;
    logic [N_DEV-1:0]   in_win;
    logic [N_DEV-1:0]   hit_oh;
    logic               hit_any;
    logic [31:0]        base_sel;
    logic [31:0]        ro_sel;
    logic               wo_sel;
    logic               misalign;
    logic               illegal;
    logic               ack_hit;

    assign accept = (state_q == S_IDLE) & req_valid_i & (req_load_i | req_store_i) & ~flush_i;

    // Window decode on the latched address; the lowest matching index wins,
    // isolated as the lowest set bit of the match vector.
    always_comb begin
        in_win   = '0;
        base_sel = '0;
        ro_sel   = '0;
        wo_sel   = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            in_win[i] = (addr_q >= DEV_BASE[i*32 +: 32]) && (addr_q <= DEV_LIMIT[i*32 +: 32]);
        end
        hit_oh  = in_win & (-in_win);
        hit_any = |in_win;
        for (int i = 0; i < N_DEV; i++) begin
            if (hit_oh[i]) begin
                base_sel = DEV_BASE[i*32 +: 32];
                ro_sel   = DEV_RO_OFS[i*32 +: 32];
                wo_sel   = DEV_WORD_ONLY[i];
            end
        end
    end

    always_comb begin
        misalign = ((size_q == 2'd2) && (addr_q[1:0] != 2'b00)) ||
                   ((size_q == 2'd1) && addr_q[0]);
        illegal  = misalign ||
                   (size_q == 2'd3) ||
                   !hit_any ||
                   (wo_sel && (size_q != 2'd2)) ||
                   (store_q && ((addr_q - base_sel) >= ro_sel)) ||
                   ovf_q;
    end

    assign ack_hit = |(dev_ack_i & dev_sel_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            size_q         <= '0;
            store_q        <= 1'b0;
            ovf_q          <= 1'b0;
            cnt_q          <= '0;
            ready_q        <= 1'b0;
            stall_q        <= 1'b0;
            dev_valid_q    <= 1'b0;
            dev_sel_q      <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_adel_q     <= 1'b0;
            rsp_ades_q     <= 1'b0;
            rsp_berr_q     <= 1'b0;
            rsp_badvaddr_q <= '0;
        end else begin
            // Response outputs are only ever set on the edge entering RESP,
            // so they read zero outside the response cycle.
            rsp_valid_q    <= 1'b0;
            rsp_adel_q     <= 1'b0;
            rsp_ades_q     <= 1'b0;
            rsp_berr_q     <= 1'b0;
            rsp_badvaddr_q <= '0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        addr_q  <= req_addr_i;
                        size_q  <= req_size_i;
                        store_q <= req_store_i;
                        ovf_q   <= req_ovf_i;
                        ready_q <= 1'b0;
                        stall_q <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (flush_i) begin
                        stall_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (illegal) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_adel_q     <= ~store_q;
                        rsp_ades_q     <= store_q;
                        rsp_badvaddr_q <= addr_q;
                        stall_q        <= 1'b0;
                        state_q        <= S_RESP;
                    end else begin
                        dev_valid_q <= 1'b1;
                        dev_sel_q   <= hit_oh;
                        cnt_q       <= CW'(TIMEOUT - 1);
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        dev_valid_q <= 1'b0;
                        dev_sel_q   <= '0;
                        stall_q     <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (ack_hit) begin
                        dev_valid_q <= 1'b0;
                        dev_sel_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        stall_q     <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (cnt_q == '0) begin
                        // TIMEOUT-th WAIT cycle without ack: bus error.
                        dev_valid_q    <= 1'b0;
                        dev_sel_q      <= '0;
                        rsp_valid_q    <= 1'b1;
                        rsp_berr_q     <= 1'b1;
                        rsp_adel_q     <= ~store_q;
                        rsp_ades_q     <= store_q;
                        rsp_badvaddr_q <= addr_q;
                        stall_q        <= 1'b0;
                        state_q        <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = ready_q;
    assign stall_o        = stall_q | accept;
    assign dev_valid_o    = dev_valid_q;
    assign dev_sel_o      = dev_sel_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_adel_o     = rsp_adel_q;
    assign rsp_ades_o     = rsp_ades_q;
    assign rsp_berr_o     = rsp_berr_q;
    assign rsp_badvaddr_o = rsp_badvaddr_q;

`ifdef LSEXC_STAT_EN
    logic [15:0] stat_adel_q;
    logic [15:0] stat_ades_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_adel_q <= '0;
            stat_ades_q <= '0;
        end else if (state_q == S_RESP) begin
            if (rsp_adel_q && (stat_adel_q != 16'hFFFF)) stat_adel_q <= stat_adel_q + 16'd1;
            if (rsp_ades_q && (stat_ades_q != 16'hFFFF)) stat_ades_q <= stat_ades_q + 16'd1;
        end
    end

    assign stat_adel_o = stat_adel_q;
    assign stat_ades_o = stat_ades_q;
`else
    assign stat_adel_o = '0;
    assign stat_ades_o = '0;
`endif

endmodule
